// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - registered N:1 channel mux with explicit-select and round-robin arbitration
module mux_arb_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  last_grant_q, last_grant_d;

  logic             can_load;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             load;
  int               start_idx;
  int               cand;

  // The single output slot accepts a word when empty or being drained this cycle
  assign can_load = !out_valid_q || out_ready;

  // Pick the granted channel; an out-of-range sel matches no channel and so never aliases
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    start_idx = 0;
    cand      = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      start_idx = (int'(last_grant_q) + 1) % N;
      for (int k = 0; k < N; k++) begin
        cand = start_idx + k;
        if (cand >= N) begin
          cand = cand - N;
        end
        for (int i = 0; i < N; i++) begin
          if (!grant_vld && cand == i && in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
    end
  end

  // One-hot ready to the granted channel only, suppressed while in reset
  always_comb begin
    in_ready = '0;
    if (!rst && can_load && grant_vld) begin
      for (int i = 0; i < N; i++) begin
        if (grant_idx == SELW'(i)) begin
          in_ready[i] = 1'b1;
        end
      end
    end
  end

  // Route the granted channel's word towards the output register
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load = |(in_ready & in_valid);

  // Next state: load on input transfer, otherwise empty on drain, otherwise hold
  always_comb begin
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (load) begin
      out_data_d   = grant_data;
      out_chan_d   = grant_idx;
      out_valid_d  = 1'b1;
      last_grant_d = grant_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // State registers; pointer resets to N-1 so the first round-robin search starts at channel 0
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= SELW'(N - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
